// File: rtl/osc_pkg.sv
// osc_pkg: shared mode/state encodings and saturating negation for the PSK quadrature oscillator
package osc_pkg;
  localparam logic [1:0] MODE_SINE = 2'd0;
  localparam logic [1:0] MODE_COS  = 2'd1;
  localparam logic [1:0] MODE_BPSK = 2'd2;
  localparam logic [1:0] MODE_OOK  = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;
  // Negate a w-bit two's-complement value held sign-extended in 32 bits; the most negative value clips to the most positive.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x, input int unsigned w);
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< (w - 1));
    return (x == lo) ? ~lo : -x;
  endfunction
endpackage

// File: rtl/quad_osc_core.sv
// quad_osc_core: magic-circle sine/cosine state pair with load port and tick-enabled update
module quad_osc_core import osc_pkg::*; #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         tick_i,
  input  logic [W-1:0] amp_i,
  input  logic [3:0]   k_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] c_o
);
  logic signed [W-1:0] s_q, c_q, s_d, c_d;
  // The cosine update uses the freshly computed sine, which keeps the orbit closed.
  always_comb begin
    s_d = s_q + (c_q >>> k_i);
    c_d = c_q - (s_d >>> k_i);
  end
  assign s_o = s_d;
  assign c_o = c_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      c_q <= '0;
    end else if (load_i) begin
      s_q <= '0;
      c_q <= amp_i;
    end else if (tick_i) begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end
endmodule

// File: rtl/psk_quad_oscillator.sv
// psk_quad_oscillator: rate-divided quadrature oscillator with symbol-driven BPSK/OOK output modulator
module psk_quad_oscillator import osc_pkg::*; #(
  parameter int W       = 16,
  parameter int OUT_W   = 8,
  parameter int DIV     = 4,
  parameter int SYM_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [W-1:0]     amp,
  input  logic [3:0]       k,
  input  logic [1:0]       mode,
  input  logic             sym_data,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic [OUT_W-1:0] wave,
  output logic             wave_valid,
  output logic             busy,
  output logic             underrun
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d;
  logic [3:0] k_q, k_d;
  logic hold_q, hold_d, full_q, full_d, cur_q, cur_d, und_q, und_d, valid_q, valid_d;
  logic [OUT_W-1:0] wave_q, wave_d, mod_w;
  logic [W-1:0] s_n, c_n;
  logic signed [OUT_W-1:0] x;
  logic run, load, tick, bound, xfer;
  assign run       = state_q == ST_RUN;
  assign load      = state_q == ST_LOAD;
  assign tick      = run && !stop && div_q == DW'(DIV - 1);
  assign bound     = tick && sym_cnt_q == SW'(SYM_LEN - 1);
  assign sym_ready = run && !full_q;
  assign xfer      = sym_valid && sym_ready;
  assign x         = OUT_W'($signed(mode == MODE_COS ? c_n : s_n) >>> (W - OUT_W));
  // The sample leaving on a boundary tick still carries the old symbol.
  assign mod_w = (mode == MODE_BPSK && !cur_q) ? OUT_W'(sat_neg(32'(x), OUT_W)) :
                 (mode == MODE_OOK && !cur_q) ? '0 : x;
  quad_osc_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .tick_i (tick),
    .amp_i  (amp),
    .k_i    (k_q),
    .s_o    (s_n),
    .c_o    (c_n)
  );
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sym_cnt_d = sym_cnt_q;
    k_d       = k_q;
    hold_d    = hold_q;
    full_d    = full_q;
    cur_d     = cur_q;
    und_d     = und_q;
    valid_d   = tick;
    wave_d    = wave_q;
    case (state_q)
      ST_IDLE: begin
        state_d = start ? ST_LOAD : ST_IDLE;
        full_d  = 1'b0;
        wave_d  = '0;
      end
      ST_LOAD: begin
        state_d   = ST_RUN;
        k_d       = k;
        div_d     = '0;
        sym_cnt_d = '0;
        cur_d     = 1'b1;
        full_d    = 1'b0;
        und_d     = 1'b0;
      end
      default: begin
        if (stop) begin
          state_d   = ST_IDLE;
          full_d    = 1'b0;
          wave_d    = '0;
          div_d     = '0;
          sym_cnt_d = '0;
        end else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (xfer) begin
            hold_d = sym_data;
            full_d = 1'b1;
          end
          if (tick) begin
            wave_d    = mod_w;
            sym_cnt_d = bound ? '0 : sym_cnt_q + 1'b1;
          end
          // A same-cycle transfer is visible at the boundary.
          if (bound) begin
            cur_d  = full_q ? hold_q : (xfer && sym_data);
            full_d = 1'b0;
            und_d  = und_q | !(full_q | xfer);
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      sym_cnt_q <= '0;
      k_q       <= '0;
      hold_q    <= 1'b0;
      full_q    <= 1'b0;
      cur_q     <= 1'b0;
      und_q     <= 1'b0;
      valid_q   <= 1'b0;
      wave_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sym_cnt_q <= sym_cnt_d;
      k_q       <= k_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
      cur_q     <= cur_d;
      und_q     <= und_d;
      valid_q   <= valid_d;
      wave_q    <= wave_d;
    end
  end
  assign wave       = wave_q;
  assign wave_valid = valid_q;
  assign busy       = state_q != ST_IDLE;
  assign underrun   = und_q;
endmodule
